// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Merges two byte streams onto one UART transmitter input. A single
//   registered output byte sits between the requesters and the UART. With
//   LOCK_ON_NEWLINE set, a requester that starts a line keeps the UART until
//   it sends 8'h0a, so text lines from the CPU and the debug echo source never
//   interleave. A lock whose owner stays silent for LOCK_TIMEOUT cycles is
//   dropped so a stalled owner cannot starve the other source.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   req0_data/valid/ready   requester 0 (CPU MMIO store path)
//   req1_data/valid/ready   requester 1 (hardware debug/echo)
//   tx_data/valid, tx_ready registered byte towards the UART transmitter
//   lock_owner              00 unlocked, 01 locked to req0, 10 locked to req1
module uart_tx_arbiter #(
  parameter int LOCK_ON_NEWLINE = 1,
  parameter int LOCK_TIMEOUT    = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [1:0] lock_owner
);

  localparam int             CW      = $clog2(LOCK_TIMEOUT);
  localparam logic [CW-1:0]  CNT_MAX = CW'(LOCK_TIMEOUT - 1);
  localparam logic [7:0]     NL      = 8'h0a;

  // Encoding doubles as the lock_owner output.
  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'b00,
    ST_LOCK0    = 2'b01,
    ST_LOCK1    = 2'b10
  } state_e;

  state_e          state_q;
  logic            rr_last_q;
  logic [CW-1:0]   cnt_q;
  logic [7:0]      tx_data_q;
  logic            tx_valid_q;

  logic [1:0]      req_valid;
  logic [1:0][7:0] req_data;
  logic [1:0]      gnt;
  logic [1:0]      hs;
  logic            slot_free;
  logic            hs_any;
  logic            hs_idx;
  logic [7:0]      hs_data;
  logic            hs_nl;
  logic            own_idx;
  logic            own_valid;

  assign req_valid = {req1_valid, req0_valid};
  assign req_data  = {req1_data, req0_data};

  // Output slot can take a byte when empty or draining this cycle.
  assign slot_free = !tx_valid_q || tx_ready;

  // Grant is a function of valids and lock state only; data never steers it.
  always_comb begin
    gnt = 2'b00;
    unique case (state_q)
      ST_UNLOCKED: begin
        if (req_valid == 2'b11) gnt = rr_last_q ? 2'b01 : 2'b10;
        else                    gnt = req_valid;
      end
      ST_LOCK0: gnt = {1'b0, req_valid[0]};
      ST_LOCK1: gnt = {req_valid[1], 1'b0};
      default:  gnt = 2'b00;
    endcase
  end

  // rst_n gates ready so nothing handshakes while reset is held.
  for (genvar i = 0; i < 2; i++) begin : g_rdy
    assign hs[i] = gnt[i] && slot_free && rst_n;
  end

  assign req0_ready = hs[0];
  assign req1_ready = hs[1];

  assign hs_any  = |hs;
  assign hs_idx  = hs[1];
  assign hs_data = req_data[hs_idx];
  assign hs_nl   = (hs_data == NL);

  assign own_idx   = (state_q == ST_LOCK1);
  assign own_valid = req_valid[own_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_UNLOCKED;
      rr_last_q  <= 1'b1;
      cnt_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      // Load wins over drain, so a drain+load cycle keeps tx_valid high.
      if (hs_any) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= hs_data;
        rr_last_q  <= hs_idx;
      end else if (tx_ready) begin
        tx_valid_q <= 1'b0;
      end

      unique case (state_q)
        ST_UNLOCKED: begin
          cnt_q <= '0;
          if (hs_any && (LOCK_ON_NEWLINE != 0) && !hs_nl)
            state_q <= hs_idx ? ST_LOCK1 : ST_LOCK0;
        end
        ST_LOCK0, ST_LOCK1: begin
          if (hs_any) begin
            cnt_q <= '0;
            if (hs_nl) state_q <= ST_UNLOCKED;
          end else if (!own_valid) begin
            // Owner silent: count idle cycles, drop the lock at the limit and
            // hand the tie-break to the other requester.
            if (cnt_q == CNT_MAX) begin
              state_q   <= ST_UNLOCKED;
              rr_last_q <= own_idx;
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q <= ST_UNLOCKED;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign lock_owner = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: one locking instance (u_lk) and one pure
// round-robin instance (u_rr) share stimulus; a rule-level model of each is
// compared every cycle, plus directed scenarios with fixed expectations.
module tb_uart_tx_arbiter;
  localparam int LT = 8;

  logic       clk, rst_n;
  logic [7:0] req0_data, req1_data;
  logic       req0_valid, req1_valid, tx_ready;
  logic       lk_r0, lk_r1, lk_tv, rr_r0, rr_r1, rr_tv;
  logic [7:0] lk_td, rr_td;
  logic [1:0] lk_lo, rr_lo;

  uart_tx_arbiter #(.LOCK_ON_NEWLINE(1), .LOCK_TIMEOUT(LT)) u_lk (
    .clk(clk), .rst_n(rst_n),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(lk_r0),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(lk_r1),
    .tx_data(lk_td), .tx_valid(lk_tv), .tx_ready(tx_ready), .lock_owner(lk_lo));

  uart_tx_arbiter #(.LOCK_ON_NEWLINE(0), .LOCK_TIMEOUT(LT)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(rr_r0),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(rr_r1),
    .tx_data(rr_td), .tx_valid(rr_tv), .tx_ready(tx_ready), .lock_owner(rr_lo));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Model: owner -1 = unlocked; idle = silent cycles of the lock owner.
  int         m_own[2], m_rr[2], m_idle[2], nx_own[2], nx_rr[2], nx_idle[2];
  bit         m_tv[2], nx_tv[2];
  logic [7:0] m_td[2], nx_td[2];
  logic [7:0] dq0[$], dq1[$];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit er0, er1, sf, ov;
      int hs;
      logic [7:0] hd;
      er0 = 0; er1 = 0;
      if (!rst_n) begin
        m_own[k] = -1; m_rr[k] = 1; m_idle[k] = 0; m_tv[k] = 0; m_td[k] = 8'h00;
      end else begin
        sf = !m_tv[k] || tx_ready;
        if (m_own[k] < 0) begin
          if (req0_valid && req1_valid) begin
            if (m_rr[k] == 1) er0 = sf; else er1 = sf;
          end else begin
            er0 = req0_valid && sf; er1 = req1_valid && sf;
          end
        end else if (m_own[k] == 0) er0 = req0_valid && sf;
        else er1 = req1_valid && sf;
      end
      chk($sformatf("rdy0_%0d", k), k == 0 ? lk_r0 : rr_r0, er0);
      chk($sformatf("rdy1_%0d", k), k == 0 ? lk_r1 : rr_r1, er1);
      chk($sformatf("txv_%0d", k),  k == 0 ? lk_tv : rr_tv, m_tv[k]);
      chk($sformatf("txd_%0d", k),  k == 0 ? lk_td : rr_td, m_td[k]);
      chk($sformatf("own_%0d", k),  k == 0 ? lk_lo : rr_lo,
          m_own[k] < 0 ? 0 : (m_own[k] == 0 ? 1 : 2));
      nx_own[k] = m_own[k]; nx_rr[k] = m_rr[k]; nx_idle[k] = m_idle[k];
      nx_tv[k] = m_tv[k]; nx_td[k] = m_td[k];
      if (rst_n) begin
        if (m_tv[k] && tx_ready) begin
          if (k == 0) dq0.push_back(m_td[k]); else dq1.push_back(m_td[k]);
        end
        hs = er0 ? 0 : (er1 ? 1 : -1);
        hd = (hs == 1) ? req1_data : req0_data;
        if (hs >= 0) begin
          nx_tv[k] = 1; nx_td[k] = hd; nx_rr[k] = hs; nx_idle[k] = 0;
          if (m_own[k] < 0) begin
            if (k == 0 && hd != 8'h0a) nx_own[k] = hs;
          end else if (hd == 8'h0a) nx_own[k] = -1;
        end else begin
          if (tx_ready) nx_tv[k] = 0;
          if (m_own[k] >= 0) begin
            ov = (m_own[k] == 0) ? req0_valid : req1_valid;
            if (!ov) begin
              if (m_idle[k] == LT - 1) begin
                nx_own[k] = -1; nx_rr[k] = m_own[k]; nx_idle[k] = 0;
              end else nx_idle[k] = m_idle[k] + 1;
            end
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_own[k] = nx_own[k]; m_rr[k] = nx_rr[k]; m_idle[k] = nx_idle[k];
      m_tv[k] = nx_tv[k]; m_td[k] = nx_td[k];
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; req0_data = 8'h00; req1_data = 8'h00;
  endtask

  // Reset asserted between edges and released with requesters idle.
  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 0;
    idle_inputs();
    @(negedge clk); @(negedge clk); #2;
    rst_n = 1;
    step();
  endtask

  task automatic send0(input logic [7:0] d);
    bit got = 0;
    req0_data = d; req0_valid = 1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk); got = lk_r0;
      @(posedge clk); #1;
    end
    chk("send0_accepted", got, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pv, pr;
    rst_n = 0; tx_ready = 0;
    idle_inputs();
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    step();

    // Round robin without locking: 41,42,41,42 starting with 41.
    dq1.delete();
    req0_valid = 1; req0_data = 8'h41; req1_valid = 1; req1_data = 8'h42; tx_ready = 1;
    repeat (6) step();
    chk("rr_len", dq1.size() >= 4, 1);
    if (dq1.size() >= 4) begin
      chk("rr_b0", dq1[0], 8'h41); chk("rr_b1", dq1[1], 8'h42);
      chk("rr_b2", dq1[2], 8'h41); chk("rr_b3", dq1[3], 8'h42);
    end

    // Line lock: "151\n" from req0 while req1 waits with 78.
    do_reset();
    dq0.delete();
    tx_ready = 1; req1_valid = 1; req1_data = 8'h78;
    send0(8'h31);
    chk("lock_after_first", lk_lo, 2'b01);
    send0(8'h35);
    send0(8'h31);
    chk("lock_before_nl", lk_lo, 2'b01);
    send0(8'h0a);
    req0_valid = 0;
    chk("unlock_after_nl", lk_lo, 2'b00);
    repeat (3) step();
    chk("line_len", dq0.size() >= 5, 1);
    if (dq0.size() >= 5) begin
      chk("line_b0", dq0[0], 8'h31); chk("line_b1", dq0[1], 8'h35);
      chk("line_b2", dq0[2], 8'h31); chk("line_b3", dq0[3], 8'h0a);
      chk("line_b4", dq0[4], 8'h78);
    end

    // Lock timeout: LT cycles after the last handshake, then req1 granted.
    do_reset();
    tx_ready = 1;
    send0(8'h55);
    req0_valid = 0; req1_valid = 1; req1_data = 8'h0a;
    n = 0;
    while (lk_lo != 2'b00 && n < 20) begin step(); n++; end
    chk("timeout_cycles", n, LT);
    chk("rdy1_after_timeout", lk_r1, 1);
    step();
    chk("req1_byte_after_timeout", lk_td, 8'h0a);

    // Back-pressure for 20 cycles, then drain and reload in one cycle.
    do_reset();
    tx_ready = 0;
    req0_valid = 1; req0_data = 8'h5a; req1_valid = 1; req1_data = 8'h0a;
    step();
    req0_data = 8'h66;
    for (int i = 0; i < 20; i++) begin
      chk("bp_data", lk_td, 8'h5a);
      chk("bp_rdy", {lk_r1, lk_r0}, 2'b00);
      step();
    end
    tx_ready = 1; #1;
    chk("bp_release_rdy0", lk_r0, 1);
    step();
    chk("bp_reload_valid", lk_tv, 1);
    chk("bp_reload_data", lk_td, 8'h66);

    // Async reset during LOCK1 with a byte pending.
    do_reset();
    tx_ready = 0; req0_valid = 0; req1_valid = 1; req1_data = 8'h21;
    step(); step();
    chk("pre_rst_owner", lk_lo, 2'b10);
    chk("pre_rst_valid", lk_tv, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_valid", lk_tv, 0);
    chk("async_rst_owner", lk_lo, 2'b00);
    chk("async_rst_rdy", {lk_r1, lk_r0}, 2'b00);
    idle_inputs();
    @(negedge clk); @(negedge clk); #2 rst_n = 1;
    step();
    req0_valid = 1; req0_data = 8'h30; req1_valid = 1; req1_data = 8'h31; tx_ready = 1;
    step();
    chk("post_rst_tie", lk_td, 8'h30);

    // Randomized traffic in phases of differing load and back-pressure.
    pv = 50; pr = 80;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        pv = (c % 192 == 0) ? 10 : ((c % 128 == 0) ? 90 : 50);
        pr = 30 + 35 * $urandom_range(2);
      end
      req0_valid = $urandom_range(99) < pv;
      req1_valid = $urandom_range(99) < pv;
      req0_data  = ($urandom_range(3) == 0) ? 8'h0a : 8'($urandom);
      req1_data  = ($urandom_range(3) == 0) ? 8'h0a : 8'($urandom);
      tx_ready   = $urandom_range(99) < pr;
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
